vga_console_ctrl: RTL and testbench



---
 rtl/vga_console_pkg.sv | 30 +++
 rtl/vga_console_ctrl_if.sv | 26 ++
 rtl/vga_console_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_vga_console_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_console_pkg.sv
// Shared types and constants for the VGA text-console write controller.
package vga_console_pkg;

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned ROW_W     = 5;
  localparam int unsigned COL_W     = 7;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned PHYS_ROWS = 32;

  localparam logic [DATA_W-1:0] CH_BS       = 8'h08;
  localparam logic [DATA_W-1:0] CH_LF       = 8'h0A;
  localparam logic [DATA_W-1:0] CH_FF       = 8'h0C;
  localparam logic [DATA_W-1:0] CH_CR       = 8'h0D;
  localparam logic [DATA_W-1:0] CH_SP       = 8'h20;
  localparam logic [DATA_W-1:0] CH_PRINT_LO = 8'h20;
  localparam logic [DATA_W-1:0] CH_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PUT      = 2'd1,
    CLR_LINE = 2'd2,
    CLR_ALL  = 2'd3
  } state_e;

  function automatic logic is_printable(input logic [DATA_W-1:0] c);
    return (c >= CH_PRINT_LO) && (c <= CH_PRINT_HI);
  endfunction

endpackage

// File: rtl/vga_console_ctrl_if.sv
// CPU byte stream, VRAM write port and console status bundled as one port.
interface vga_console_ctrl_if;
  import vga_console_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_char;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ROW_W-1:0]  top_row;
  logic [ROW_W-1:0]  cursor_row;
  logic [COL_W-1:0]  cursor_col;
  logic              busy;

  modport master (
    output in_valid, in_char,
    input  in_ready, wr_en, wr_addr, wr_data, top_row, cursor_row, cursor_col, busy
  );

  modport slave (
    input  in_valid, in_char,
    output in_ready, wr_en, wr_addr, wr_data, top_row, cursor_row, cursor_col, busy
  );

endinterface

// File: rtl/vga_console_ctrl.sv
// Text-console write controller: cursor tracking, control codes, VRAM byte
// writes and hardware scroll via a top-row offset with pre-visible line clear.
module vga_console_ctrl
  import vga_console_pkg::*;
#(
  parameter int unsigned COLS           = 70,
  parameter int unsigned ROWS           = 30,
  parameter int unsigned ROW_STRIDE_LG2 = 7
) (
  input  logic              clk,
  input  logic              reset,
  vga_console_ctrl_if.slave bus
);

  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] SCROLL_OFS = ROW_W'(ROWS);
  localparam logic [ROW_W-1:0] LAST_PHYS  = ROW_W'(PHYS_ROWS - 1);
  localparam logic [CNT_W-1:0] COLS_CNT   = CNT_W'(COLS);

  state_e state, state_nxt;

  logic              wr_en_q,   wr_en_nxt;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_nxt;
  logic [DATA_W-1:0] wr_data_q, wr_data_nxt;
  logic [ROW_W-1:0]  top_q,     top_nxt;
  logic [ROW_W-1:0]  row_q,     row_nxt;
  logic [COL_W-1:0]  col_q,     col_nxt;
  logic [ROW_W-1:0]  clr_row_q, clr_row_nxt;
  logic [CNT_W-1:0]  clr_col_q, clr_col_nxt;
  logic              scroll_q,  scroll_nxt;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [ROW_W-1:0] r,
                                                input logic [COL_W-1:0] c);
    return (ADDR_W'(r) << ROW_STRIDE_LG2) | ADDR_W'(c);
  endfunction

  logic             accept;
  logic             is_print, is_cr, is_lf, is_bs, is_ff;
  logic             at_last_row, at_home;
  logic [ROW_W-1:0] cur_phys, prev_phys, scroll_phys;

  assign accept      = bus.in_valid && (state == IDLE);
  assign is_print    = is_printable(bus.in_char);
  assign is_cr       = (bus.in_char == CH_CR);
  assign is_lf       = (bus.in_char == CH_LF);
  assign is_bs       = (bus.in_char == CH_BS);
  assign is_ff       = (bus.in_char == CH_FF);
  assign at_last_row = (row_q == LAST_ROW);
  assign at_home     = (row_q == '0) && (col_q == '0);
  assign cur_phys    = ROW_W'(top_q + row_q);
  assign prev_phys   = ROW_W'(top_q + row_q - ROW_W'(1));
  // The row just below the visible window; cleared before it scrolls in.
  assign scroll_phys = ROW_W'(top_q + SCROLL_OFS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (is_print)                 state_nxt = PUT;
          else if (is_lf && at_last_row) state_nxt = CLR_LINE;
          else if (is_bs && !at_home)    state_nxt = PUT;
          else if (is_ff)                state_nxt = CLR_ALL;
        end
      end
      PUT:      state_nxt = scroll_q ? CLR_LINE : IDLE;
      // wr_en_q low marks the bookkeeping cycle after the last clear write.
      CLR_LINE: if (!wr_en_q) state_nxt = IDLE;
      CLR_ALL:  if (!wr_en_q) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr_q;
    wr_data_nxt = wr_data_q;
    top_nxt     = top_q;
    row_nxt     = row_q;
    col_nxt     = col_q;
    clr_row_nxt = clr_row_q;
    clr_col_nxt = clr_col_q;
    scroll_nxt  = scroll_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (is_print) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = addr_of(cur_phys, col_q);
            wr_data_nxt = bus.in_char;
            if (col_q != LAST_COL) begin
              col_nxt = col_q + COL_W'(1);
            end else begin
              col_nxt = '0;
              if (!at_last_row) row_nxt = row_q + ROW_W'(1);
              else              scroll_nxt = 1'b1;
            end
          end else if (is_cr) begin
            col_nxt = '0;
          end else if (is_lf) begin
            col_nxt = '0;
            if (!at_last_row) begin
              row_nxt = row_q + ROW_W'(1);
            end else begin
              wr_en_nxt   = 1'b1;
              wr_addr_nxt = addr_of(scroll_phys, '0);
              wr_data_nxt = CH_SP;
              clr_col_nxt = CNT_W'(1);
            end
          end else if (is_bs) begin
            if (col_q != '0) begin
              col_nxt     = col_q - COL_W'(1);
              wr_en_nxt   = 1'b1;
              wr_addr_nxt = addr_of(cur_phys, col_q - COL_W'(1));
              wr_data_nxt = CH_SP;
            end else if (row_q != '0) begin
              row_nxt     = row_q - ROW_W'(1);
              col_nxt     = LAST_COL;
              wr_en_nxt   = 1'b1;
              wr_addr_nxt = addr_of(prev_phys, LAST_COL);
              wr_data_nxt = CH_SP;
            end
          end else if (is_ff) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = addr_of('0, '0);
            wr_data_nxt = CH_SP;
            clr_row_nxt = '0;
            clr_col_nxt = CNT_W'(1);
          end
        end
      end
      PUT: begin
        scroll_nxt = 1'b0;
        if (scroll_q) begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = addr_of(scroll_phys, '0);
          wr_data_nxt = CH_SP;
          clr_col_nxt = CNT_W'(1);
        end
      end
      CLR_LINE: begin
        if (wr_en_q) begin
          if (clr_col_q != COLS_CNT) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = addr_of(scroll_phys, COL_W'(clr_col_q));
            clr_col_nxt = clr_col_q + CNT_W'(1);
          end
        end else begin
          top_nxt = top_q + ROW_W'(1);
        end
      end
      CLR_ALL: begin
        if (wr_en_q) begin
          if (clr_col_q != COLS_CNT) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = addr_of(clr_row_q, COL_W'(clr_col_q));
            clr_col_nxt = clr_col_q + CNT_W'(1);
          end else if (clr_row_q != LAST_PHYS) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = addr_of(clr_row_q + ROW_W'(1), '0);
            clr_row_nxt = clr_row_q + ROW_W'(1);
            clr_col_nxt = CNT_W'(1);
          end
        end else begin
          top_nxt = '0;
          row_nxt = '0;
          col_nxt = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      top_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      clr_row_q <= '0;
      clr_col_q <= '0;
      scroll_q  <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_nxt;
      wr_addr_q <= wr_addr_nxt;
      wr_data_q <= wr_data_nxt;
      top_q     <= top_nxt;
      row_q     <= row_nxt;
      col_q     <= col_nxt;
      clr_row_q <= clr_row_nxt;
      clr_col_q <= clr_col_nxt;
      scroll_q  <= scroll_nxt;
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.top_row    = top_q;
  assign bus.cursor_row = row_q;
  assign bus.cursor_col = col_q;

endmodule

// File: tb/tb_vga_console_ctrl.sv
// Directed bench for vga_console_ctrl: vector table plus scroll/clear/reset sequences.
module tb_vga_console_ctrl;

  localparam int COLS = 70;
  localparam int ROWS = 30;

  logic clk = 1'b0;
  logic reset = 1'b1;

  vga_console_ctrl_if bus ();

  vga_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .ROW_STRIDE_LG2(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  ch;
    logic        we;
    logic [11:0] addr;
    logic [7:0]  data;
    logic        rdy;
    logic [4:0]  row;
    logic [6:0]  col;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic [7:0] ch, input logic we, input logic [11:0] addr,
                              input logic [7:0] data, input logic rdy,
                              input logic [4:0] row, input logic [6:0] col);
    vec_t v;
    v.ch = ch; v.we = we; v.addr = addr; v.data = data; v.rdy = rdy; v.row = row; v.col = col;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    while (!bus.in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("send_ready_timeout", 32'(bus.in_ready), 32'(1));
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!bus.in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("idle_timeout", 32'(bus.in_ready), 32'(1));
  endtask

  task automatic check_cursor(input string name, input int row, input int col);
    check({name, "_row"}, 32'(bus.cursor_row), 32'(row));
    check({name, "_col"}, 32'(bus.cursor_col), 32'(col));
  endtask

  // Count busy cycles and clear writes until in_ready returns, checking each address.
  task automatic measure(input string name, input bit all, input int row,
                         input int exp_writes, input int exp_cycles);
    int cyc, writes, bad, busy_low;
    logic [11:0] ea;
    cyc = 0; writes = 0; bad = 0; busy_low = 0;
    while (!bus.in_ready && cyc < 3000) begin
      if (!bus.busy) busy_low++;
      if (bus.wr_en) begin
        if (all) ea = 12'(((writes / COLS) << 7) | (writes % COLS));
        else     ea = 12'((row << 7) | writes);
        if (bus.wr_addr !== ea || bus.wr_data !== 8'h20) bad++;
        writes++;
      end
      cyc++;
      @(negedge clk);
    end
    check({name, "_cycles"}, 32'(cyc), 32'(exp_cycles));
    check({name, "_writes"}, 32'(writes), 32'(exp_writes));
    check({name, "_bad_addr"}, 32'(bad), 32'(0));
    check({name, "_busy_low"}, 32'(busy_low), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;

    vecs[0]  = mk(8'h41, 1, 12'h000, 8'h41, 0, 0, 1);
    vecs[1]  = mk(8'h42, 1, 12'h001, 8'h42, 0, 0, 2);
    vecs[2]  = mk(8'h0D, 0, 12'h000, 8'h00, 1, 0, 0);
    vecs[3]  = mk(8'h0A, 0, 12'h000, 8'h00, 1, 1, 0);
    vecs[4]  = mk(8'h78, 1, 12'h080, 8'h78, 0, 1, 1);
    vecs[5]  = mk(8'h08, 1, 12'h080, 8'h20, 0, 1, 0);
    vecs[6]  = mk(8'h08, 1, 12'h045, 8'h20, 0, 0, 69);
    vecs[7]  = mk(8'h5A, 1, 12'h045, 8'h5A, 0, 1, 0);
    vecs[8]  = mk(8'h01, 0, 12'h000, 8'h00, 1, 1, 0);
    vecs[9]  = mk(8'h7F, 0, 12'h000, 8'h00, 1, 1, 0);
    vecs[10] = mk(8'h7E, 1, 12'h080, 8'h7E, 0, 1, 1);
    vecs[11] = mk(8'h20, 1, 12'h081, 8'h20, 0, 1, 2);
    vecs[12] = mk(8'h1F, 0, 12'h000, 8'h00, 1, 1, 2);
    vecs[13] = mk(8'h0D, 0, 12'h000, 8'h00, 1, 1, 0);
    vecs[14] = mk(8'h0A, 0, 12'h000, 8'h00, 1, 2, 0);
    vecs[15] = mk(8'h08, 1, 12'h0C5, 8'h20, 0, 1, 69);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_wr_en",   32'(bus.wr_en),   32'(0));
    check("rst_wr_addr", 32'(bus.wr_addr), 32'(0));
    check("rst_wr_data", 32'(bus.wr_data), 32'(0));
    check("rst_top_row", 32'(bus.top_row), 32'(0));
    check("rst_busy",    32'(bus.busy),    32'(0));
    check("rst_ready",   32'(bus.in_ready), 32'(1));
    check_cursor("rst", 0, 0);

    for (int i = 0; i < 16; i++) begin
      send(vecs[i].ch);
      check($sformatf("v%0d_wr_en", i), 32'(bus.wr_en), 32'(vecs[i].we));
      if (vecs[i].we) begin
        check($sformatf("v%0d_wr_addr", i), 32'(bus.wr_addr), 32'(vecs[i].addr));
        check($sformatf("v%0d_wr_data", i), 32'(bus.wr_data), 32'(vecs[i].data));
      end
      check($sformatf("v%0d_ready", i), 32'(bus.in_ready), 32'(vecs[i].rdy));
      check_cursor($sformatf("v%0d", i), int'(vecs[i].row), int'(vecs[i].col));
      wait_idle();
    end

    // PUT latency: in_ready low at t+1, high at t+2
    send(8'h0D);
    send(8'h51);
    check("put_ready_t1", 32'(bus.in_ready), 32'(0));
    @(negedge clk);
    check("put_ready_t2", 32'(bus.in_ready), 32'(1));
    check("put_wr_en_t2", 32'(bus.wr_en), 32'(0));
    check_cursor("put", 1, 1);
    send(8'h0D);

    // Full line of 70 bytes on row 1 wraps to row 2
    for (int i = 0; i < COLS; i++) begin
      send(8'(8'h30 + i % 10));
      if (i == COLS - 1) begin
        check("line_last_addr", 32'(bus.wr_addr), 32'h0C5);
        check("line_last_data", 32'(bus.wr_data), 32'(8'h30 + (COLS - 1) % 10));
      end
      wait_idle();
    end
    check_cursor("line", 2, 0);
    send(8'h0D);
    check("crlf_cr_wr_en", 32'(bus.wr_en), 32'(0));
    send(8'h0A);
    check("crlf_lf_wr_en", 32'(bus.wr_en), 32'(0));
    check_cursor("crlf", 3, 0);

    // Walk to the last row, then scroll 32 times to wrap top_row
    for (int i = 0; i < 26; i++) send(8'h0A);
    check_cursor("row29", 29, 0);
    for (int k = 0; k < 32; k++) begin
      send(8'h0A);
      measure($sformatf("scroll%0d", k), 1'b0, (k + 30) % 32, COLS, COLS + 1);
      check($sformatf("scroll%0d_top", k), 32'(bus.top_row), 32'((k + 1) % 32));
      check_cursor($sformatf("scroll%0d", k), 29, 0);
    end

    // Printable at the bottom-right corner: PUT then line clear
    for (int i = 0; i < COLS - 1; i++) send(8'h6B);
    send(8'h45);
    check("corner_wr_en",   32'(bus.wr_en),   32'(1));
    check("corner_wr_addr", 32'(bus.wr_addr), 32'hEC5);
    check("corner_wr_data", 32'(bus.wr_data), 32'h45);
    @(negedge clk);
    measure("corner_clr", 1'b0, 30, COLS, COLS + 1);
    check("corner_top", 32'(bus.top_row), 32'(1));
    check_cursor("corner", 29, 0);

    // Form feed clears all 32 physical rows
    send(8'h0C);
    measure("ff", 1'b1, 0, 32 * COLS, 32 * COLS + 1);
    check("ff_top", 32'(bus.top_row), 32'(0));
    check_cursor("ff", 0, 0);

    // Backspace at home is a no-op
    send(8'h08);
    check("bs_home_wr_en", 32'(bus.wr_en),    32'(0));
    check("bs_home_ready", 32'(bus.in_ready), 32'(1));
    check_cursor("bs_home", 0, 0);

    // Reset 100 cycles into a form feed
    send(8'h41);
    wait_idle();
    send(8'h0C);
    repeat (100) @(negedge clk);
    check("midclr_busy", 32'(bus.busy), 32'(1));
    #2 reset = 1'b1;
    #1;
    check("arst_wr_en",   32'(bus.wr_en),   32'(0));
    check("arst_wr_addr", 32'(bus.wr_addr), 32'(0));
    check("arst_wr_data", 32'(bus.wr_data), 32'(0));
    check("arst_top",     32'(bus.top_row), 32'(0));
    check("arst_busy",    32'(bus.busy),    32'(0));
    check_cursor("arst", 0, 0);
    @(negedge clk);
    reset = 1'b0;
    check("arst_ready", 32'(bus.in_ready), 32'(1));
    send(8'h41);
    check("post_rst_wr_en",   32'(bus.wr_en),   32'(1));
    check("post_rst_wr_addr", 32'(bus.wr_addr), 32'h000);
    check_cursor("post_rst", 0, 1);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
